// File: rtl/axil_mmio_timer.sv
// AXI4-Lite slave wrapping a 32-bit free-running timer with compare/match interrupt.
// Build option AXIL_TIMER_SLVERR_EN: unmapped accesses answer SLVERR instead of OKAY.
module axil_mmio_timer #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset_N,
    input  logic [ADDR_WIDTH-1:0]   s_axil_awaddr,
    input  logic                    s_axil_awvalid,
    output logic                    s_axil_awready,
    input  logic [DATA_WIDTH-1:0]   s_axil_wdata,
    input  logic [DATA_WIDTH/8-1:0] s_axil_wstrb,
    input  logic                    s_axil_wvalid,
    output logic                    s_axil_wready,
    output logic [1:0]              s_axil_bresp,
    output logic                    s_axil_bvalid,
    input  logic                    s_axil_bready,
    input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
    input  logic                    s_axil_arvalid,
    output logic                    s_axil_arready,
    output logic [DATA_WIDTH-1:0]   s_axil_rdata,
    output logic [1:0]              s_axil_rresp,
    output logic                    s_axil_rvalid,
    input  logic                    s_axil_rready,
    output logic                    o_Irq
);

    localparam int SW = DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef AXIL_TIMER_SLVERR_EN
    localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
    localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif
    localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_HAVE_ADDR = 2'd1,
        W_HAVE_DATA = 2'd2,
        W_RESP      = 2'd3
    } w_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } r_state_e;

    function automatic logic is_mapped(input logic [ADDR_WIDTH-1:0] addr);
        return (addr[ADDR_WIDTH-1:4] == '0) && (addr[1:0] == 2'b00);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(input logic [DATA_WIDTH-1:0] old_val,
                                                          input logic [DATA_WIDTH-1:0] new_val,
                                                          input logic [SW-1:0]         strb);
        logic [DATA_WIDTH-1:0] res;
        res = old_val;
        for (int b = 0; b < SW; b++) begin
            if (strb[b]) begin
                res[8*b +: 8] = new_val[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_val[8*b +: 8];
            end
        end
        return res;
    endfunction

    w_state_e              w_state_q, w_state_d;
    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [SW-1:0]         wstrb_q;
    logic [1:0]            bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [2:0]            ctrl_q, ctrl_d;
    logic [DATA_WIDTH-1:0] count_q, count_d, compare_q, compare_d;
    logic                  status_q, status_d, irq_q;

    logic                  aw_hs_s, w_hs_s, ar_hs_s, wr_en_s, match_s, status_clr_s;
    logic [ADDR_WIDTH-1:0] wr_addr_s;
    logic [DATA_WIDTH-1:0] wr_data_s, rd_value_s;
    logic [SW-1:0]         wr_strb_s;
    logic [3:0]            wr_sel_s;

    assign aw_hs_s = s_axil_awvalid & s_axil_awready;
    assign w_hs_s  = s_axil_wvalid & s_axil_wready;
    assign ar_hs_s = s_axil_arvalid & s_axil_arready;

    // Write FSM state register.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            w_state_q <= W_IDLE;
        end else begin
            w_state_q <= w_state_d;
        end
    end

    // Write FSM next state: AW and W may arrive together or in either order.
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) w_state_d = W_RESP;
                else if (aw_hs_s)      w_state_d = W_HAVE_ADDR;
                else if (w_hs_s)       w_state_d = W_HAVE_DATA;
                else                   w_state_d = W_IDLE;
            end
            W_HAVE_ADDR: if (w_hs_s) w_state_d = W_RESP; else w_state_d = W_HAVE_ADDR;
            W_HAVE_DATA: if (aw_hs_s) w_state_d = W_RESP; else w_state_d = W_HAVE_DATA;
            W_RESP:      if (s_axil_bready) w_state_d = W_IDLE; else w_state_d = W_RESP;
            default:     w_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs; readies stay low while reset is asserted.
    always_comb begin
        s_axil_awready = 1'b0;
        s_axil_wready  = 1'b0;
        s_axil_bvalid  = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                s_axil_awready = i_Reset_N;
                s_axil_wready  = i_Reset_N;
            end
            W_HAVE_ADDR: s_axil_wready  = i_Reset_N;
            W_HAVE_DATA: s_axil_awready = i_Reset_N;
            W_RESP:      s_axil_bvalid  = 1'b1;
            default:     s_axil_bvalid  = 1'b0;
        endcase
    end
    assign s_axil_bresp = bresp_q;

    // Commit strobe fires on the edge where the second of AW/W completes.
    always_comb begin
        wr_en_s   = 1'b0;
        wr_addr_s = s_axil_awaddr;
        wr_data_s = s_axil_wdata;
        wr_strb_s = s_axil_wstrb;
        case (w_state_q)
            W_IDLE:      wr_en_s = aw_hs_s & w_hs_s;
            W_HAVE_ADDR: begin
                wr_en_s   = w_hs_s;
                wr_addr_s = awaddr_q;
            end
            W_HAVE_DATA: begin
                wr_en_s   = aw_hs_s;
                wr_data_s = wdata_q;
                wr_strb_s = wstrb_q;
            end
            default:     wr_en_s = 1'b0;
        endcase
        if (wr_en_s && is_mapped(wr_addr_s)) begin
            wr_sel_s = 4'b0001 << wr_addr_s[3:2];
        end else begin
            wr_sel_s = 4'b0000;
        end
    end

    // Capture of early address/data beats and the write response code.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            bresp_q  <= 2'b00;
        end else begin
            if (aw_hs_s) awaddr_q <= s_axil_awaddr;
            if (w_hs_s) begin
                wdata_q <= s_axil_wdata;
                wstrb_q <= s_axil_wstrb;
            end
            if (wr_en_s) bresp_q <= is_mapped(wr_addr_s) ? RESP_OKAY : RESP_UNMAPPED;
        end
    end

    // Timer next state: bus writes beat count/reload, a MATCH set beats a same-edge clear.
    always_comb begin
        match_s      = ctrl_q[0] && (count_q == compare_q);
        status_clr_s = wr_sel_s[3] && wr_strb_s[0] && wr_data_s[0];
        if (wr_sel_s[0] && wr_strb_s[0]) ctrl_d = wr_data_s[2:0];
        else                             ctrl_d = ctrl_q;
        if (wr_sel_s[1])                 count_d = merge_bytes(count_q, wr_data_s, wr_strb_s);
        else if (match_s && ctrl_q[2])   count_d = '0;
        else if (ctrl_q[0])              count_d = count_q + ONE;
        else                             count_d = count_q;
        if (wr_sel_s[2]) compare_d = merge_bytes(compare_q, wr_data_s, wr_strb_s);
        else             compare_d = compare_q;
        if (match_s)           status_d = 1'b1;
        else if (status_clr_s) status_d = 1'b0;
        else                   status_d = status_q;
    end

    // Timer register file and interrupt.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            ctrl_q    <= 3'b000;
            count_q   <= '0;
            compare_q <= '0;
            status_q  <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            status_q  <= status_d;
            irq_q     <= status_d & ctrl_d[1];
        end
    end
    assign o_Irq = irq_q;

    // Read FSM state register.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            r_state_q <= R_IDLE;
        end else begin
            r_state_q <= r_state_d;
        end
    end

    // Read FSM next state.
    always_comb begin
        case (r_state_q)
            R_IDLE:  if (ar_hs_s) r_state_d = R_RESP; else r_state_d = R_IDLE;
            R_RESP:  if (s_axil_rready) r_state_d = R_IDLE; else r_state_d = R_RESP;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs.
    always_comb begin
        case (r_state_q)
            R_IDLE: begin
                s_axil_arready = i_Reset_N;
                s_axil_rvalid  = 1'b0;
            end
            R_RESP: begin
                s_axil_arready = 1'b0;
                s_axil_rvalid  = 1'b1;
            end
            default: begin
                s_axil_arready = 1'b0;
                s_axil_rvalid  = 1'b0;
            end
        endcase
    end

    // Read mux over the pre-edge register values.
    always_comb begin
        case (s_axil_araddr[3:2])
            2'd0:    rd_value_s = {{(DATA_WIDTH-3){1'b0}}, ctrl_q};
            2'd1:    rd_value_s = count_q;
            2'd2:    rd_value_s = compare_q;
            2'd3:    rd_value_s = {{(DATA_WIDTH-1){1'b0}}, status_q};
            default: rd_value_s = '0;
        endcase
    end

    // Read data is frozen at acceptance so it stays stable under back-pressure.
    always_ff @(posedge i_Clock or negedge i_Reset_N) begin
        if (!i_Reset_N) begin
            rdata_q <= '0;
            rresp_q <= 2'b00;
        end else if (ar_hs_s) begin
            rdata_q <= is_mapped(s_axil_araddr) ? rd_value_s : '0;
            rresp_q <= is_mapped(s_axil_araddr) ? RESP_OKAY : RESP_UNMAPPED;
        end else begin
            rdata_q <= rdata_q;
            rresp_q <= rresp_q;
        end
    end
    assign s_axil_rdata = rdata_q;
    assign s_axil_rresp = rresp_q;

endmodule

// File: tb/tb_axil_mmio_timer.sv
// Directed + randomized bench for axil_mmio_timer against a register-level reference model.
module tb_axil_mmio_timer;

    logic        clk, rst_n;
    logic [15:0] awaddr, araddr;
    logic        awvalid, wvalid, bready, arvalid, rready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;

    int nchecks = 0;
    int nerrors = 0;

`ifdef AXIL_TIMER_SLVERR_EN
    localparam logic [1:0] ERR = 2'b10;
`else
    localparam logic [1:0] ERR = 2'b00;
`endif

    axil_mmio_timer dut (
        .i_Clock(clk), .i_Reset_N(rst_n),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .o_Irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state; mw_* announces a write committing on the next rising edge.
    logic [2:0]  m_ctrl;
    logic [31:0] m_count, m_compare;
    logic        m_status;
    logic        mw_en;
    logic [15:0] mw_addr;
    logic [31:0] mw_data;
    logic [3:0]  mw_strb;

    function automatic bit mapped(input logic [15:0] a);
        return (a[15:4] == 12'd0) && (a[1:0] == 2'd0);
    endfunction

    function automatic logic [31:0] mergeb(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
        logic [31:0] m;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return (o & ~m) | (n & m);
    endfunction

    function automatic bit wsel(input logic [1:0] r);
        return mw_en && mapped(mw_addr) && (mw_addr[3:2] == r);
    endfunction

    function automatic logic [31:0] mval(input logic [15:0] a);
        if (!mapped(a)) return 32'd0;
        case (a[3:2])
            2'd0:    return {29'd0, m_ctrl};
            2'd1:    return m_count;
            2'd2:    return m_compare;
            default: return {31'd0, m_status};
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ctrl <= 3'd0; m_count <= 32'd0; m_compare <= 32'd0; m_status <= 1'b0;
        end else begin
            m_ctrl    <= (wsel(2'd0) && mw_strb[0]) ? mw_data[2:0] : m_ctrl;
            m_compare <= wsel(2'd2) ? mergeb(m_compare, mw_data, mw_strb) : m_compare;
            if (wsel(2'd1))                                          m_count <= mergeb(m_count, mw_data, mw_strb);
            else if (m_ctrl[0] && m_ctrl[2] && m_count == m_compare) m_count <= 32'd0;
            else if (m_ctrl[0])                                      m_count <= m_count + 32'd1;
            if (m_ctrl[0] && m_count == m_compare)                   m_status <= 1'b1;
            else if (wsel(2'd3) && mw_strb[0] && mw_data[0])         m_status <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        nchecks++;
        assert (obs === req) else begin
            nerrors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        chk("irq", {31'd0, irq}, {31'd0, m_status & m_ctrl[1]});
    endtask

    task automatic finish_write(input logic [15:0] a, input int bdelay);
        repeat (bdelay) begin
            chk("bvalid_hold", {31'd0, bvalid}, 32'd1);
            chk("awready_in_resp", {31'd0, awready}, 32'd0);
            cyc();
        end
        chk("bvalid", {31'd0, bvalid}, 32'd1);
        chk("bresp", {30'd0, bresp}, {30'd0, mapped(a) ? 2'b00 : ERR});
        bready = 1'b1;
        cyc();
        bready = 1'b0;
        chk("bvalid_clr", {31'd0, bvalid}, 32'd0);
    endtask

    task automatic axi_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
        chk("awready", {31'd0, awready}, 32'd1);
        chk("wready", {31'd0, wready}, 32'd1);
        mw_en = 1'b1; mw_addr = a; mw_data = d; mw_strb = s;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0; mw_en = 1'b0;
        finish_write(a, 0);
    endtask

    // Second beat is presented gap cycles after the first.
    task automatic axi_write_split(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                                   input bit aw_first, input int gap, input int bdelay);
        if (aw_first) begin awaddr = a; awvalid = 1'b1; end
        else begin wdata = d; wstrb = s; wvalid = 1'b1; end
        chk("first_ready", {31'd0, aw_first ? awready : wready}, 32'd1);
        cyc();
        awvalid = 1'b0; wvalid = 1'b0;
        for (int i = 1; i < gap; i++) begin
            chk("bvalid_early", {31'd0, bvalid}, 32'd0);
            cyc();
        end
        if (aw_first) begin
            wdata = d; wstrb = s; wvalid = 1'b1;
            chk("wready_2nd", {31'd0, wready}, 32'd1);
            chk("awready_blocked", {31'd0, awready}, 32'd0);
        end else begin
            awaddr = a; awvalid = 1'b1;
            chk("awready_2nd", {31'd0, awready}, 32'd1);
            chk("wready_blocked", {31'd0, wready}, 32'd0);
        end
        mw_en = 1'b1; mw_addr = a; mw_data = d; mw_strb = s;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0; mw_en = 1'b0;
        finish_write(a, bdelay);
    endtask

    task automatic axi_read(input logic [15:0] a, input int hold);
        logic [31:0] er;
        logic [1:0]  rr;
        er = mval(a);
        rr = mapped(a) ? 2'b00 : ERR;
        araddr = a; arvalid = 1'b1;
        chk("arready", {31'd0, arready}, 32'd1);
        cyc();
        arvalid = 1'b0;
        chk("rvalid", {31'd0, rvalid}, 32'd1);
        chk($sformatf("rdata@%h", a), rdata, er);
        chk("rresp", {30'd0, rresp}, {30'd0, rr});
        repeat (hold) begin
            cyc();
            chk("rdata_stable", rdata, er);
            chk("rvalid_hold", {31'd0, rvalid}, 32'd1);
            chk("arready_in_resp", {31'd0, arready}, 32'd0);
        end
        rready = 1'b1;
        cyc();
        rready = 1'b0;
        chk("rvalid_clr", {31'd0, rvalid}, 32'd0);
    endtask

    task automatic read_all();
        for (int r = 0; r < 4; r++) axi_read(16'(4 * r), 0);
    endtask

    // Write and read of COMPARE accepted on the same edge; bvalid/rvalid left pending.
    task automatic concurrent_start(input logic [31:0] d);
        logic [31:0] old_val;
        old_val = m_compare;
        awaddr = 16'h8; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 16'h8; arvalid = 1'b1;
        mw_en = 1'b1; mw_addr = 16'h8; mw_data = d; mw_strb = 4'hF;
        cyc();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; mw_en = 1'b0;
        chk("conc_bvalid", {31'd0, bvalid}, 32'd1);
        chk("conc_rvalid", {31'd0, rvalid}, 32'd1);
        chk("conc_rdata_prewrite", rdata, old_val);
    endtask

    logic [15:0] addrs [7];

    initial begin
        addrs = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h2, 16'h40, 16'h10};
        rst_n = 1'b0; mw_en = 1'b0; mw_addr = 16'd0; mw_data = 32'd0; mw_strb = 4'd0;
        awaddr = 16'd0; araddr = 16'd0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arvalid = 1'b0; rready = 1'b0; wdata = 32'd0; wstrb = 4'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_awready", {31'd0, awready}, 32'd0);
        chk("rst_wready", {31'd0, wready}, 32'd0);
        chk("rst_arready", {31'd0, arready}, 32'd0);
        chk("rst_bvalid", {31'd0, bvalid}, 32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {29'd0, awready, wready, arready}, 32'd7);
        read_all();

        // Compare match with interrupt, no reload
        axi_write(16'h8, 32'h5, 4'hF);
        axi_write(16'h0, 32'h3, 4'hF);
        for (int i = 0; i < 5; i++) begin
            axi_read(16'h4, 0);
            axi_read(16'hC, 0);
        end
        axi_write(16'h0, 32'h0, 4'hF);
        axi_write(16'hC, 32'h1, 4'hF);
        axi_read(16'hC, 0);
        axi_write(16'h4, 32'h0, 4'hF);

        // Auto-reload sequence, MATCH sticky until W1C
        axi_write(16'h8, 32'h3, 4'hF);
        axi_write(16'h0, 32'h5, 4'hF);
        for (int i = 0; i < 6; i++) axi_read(16'h4, i % 2);
        axi_read(16'hC, 1);
        axi_write(16'h0, 32'h0, 4'hF);
        axi_read(16'hC, 0);
        axi_write(16'hC, 32'h1, 4'hF);
        axi_read(16'hC, 0);

        // W leads AW by 3 cycles with partial strobes, then a held response
        axi_write_split(16'h8, 32'hA5A5_A5A5, 4'b0101, 1'b0, 3, 4);
        axi_read(16'h8, 0);
        chk("compare_strobed", m_compare, 32'h00A5_00A5);
        axi_write_split(16'h4, 32'h1234_5678, 4'b1010, 1'b1, 2, 1);
        axi_read(16'h4, 0);

        // Wrap from 0xFFFFFFFF without a match
        axi_write(16'h8, 32'h10, 4'hF);
        axi_write(16'h4, 32'hFFFF_FFFE, 4'hF);
        axi_write(16'h0, 32'h3, 4'hF);
        for (int i = 0; i < 4; i++) axi_read(16'h4, 0);
        axi_read(16'hC, 0);
        axi_write(16'h0, 32'h0, 4'hF);

        // Unmapped accesses and zero strobe
        axi_read(16'h40, 0);
        axi_read(16'h2, 0);
        axi_write(16'h2, 32'hFFFF_FFFF, 4'hF);
        axi_write(16'h40, 32'hFFFF_FFFF, 4'hF);
        axi_write(16'h8, 32'hDEAD_BEEF, 4'h0);
        read_all();

        // Same-edge read and write
        concurrent_start(32'h0000_0777);
        bready = 1'b1; rready = 1'b1;
        cyc();
        bready = 1'b0; rready = 1'b0;
        chk("conc_done", {30'd0, bvalid, rvalid}, 32'd0);
        axi_read(16'h8, 0);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            logic [15:0] a;
            logic [31:0] d;
            a = addrs[$urandom_range(0, 6)];
            d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 24)) : 32'($urandom);
            case ($urandom_range(0, 2))
                0:       axi_write(a, d, 4'($urandom_range(0, 15)));
                1:       axi_write_split(a, d, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                                         $urandom_range(1, 3), $urandom_range(0, 2));
                default: axi_read(a, $urandom_range(0, 2));
            endcase
        end

        // Reset while both responses are pending
        axi_write(16'h4, 32'h9, 4'hF);
        axi_write(16'h0, 32'h3, 4'hF);
        concurrent_start(32'h0000_0042);
        rst_n = 1'b0;
        #1;
        chk("abort_valids", {30'd0, bvalid, rvalid}, 32'd0);
        chk("abort_readies", {29'd0, awready, wready, arready}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        chk("abort_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("release_ready", {29'd0, awready, wready, arready}, 32'd7);
        read_all();
        axi_write(16'h8, 32'h0000_00AB, 4'hF);
        axi_read(16'h8, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
